// File: rtl/mix_columns_seq.sv
// mix_columns_seq: steps AES MixColumns in place across the four state columns.
// Define MIX_INV_EN to add InvMixColumns, chosen by `inverse` when a pass is accepted.
module mix_columns_seq #(
    parameter int PIPE = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        inverse,
    output logic        busy,
    output logic        done,
    output logic [1:0]  rd_idx,
    output logic        rd_row_col,
    input  logic [31:0] rd_data,
    output logic        wr_en,
    output logic [1:0]  wr_idx,
    output logic        wr_row_col,
    output logic [31:0] wr_data
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0]  LAG  = 3'(PIPE);
    localparam logic [2:0]  LAST = 3'(3 + PIPE);
    localparam logic [15:0] FWD  = 16'h2311;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant using an xtime chain (covers 01..0e).
    function automatic logic [7:0] gmul4(input logic [7:0] x, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    // coef holds the first matrix row {c0,c1,c2,c3}; each later row is a right rotation.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic [15:0] coef);
        logic [7:0]  r;
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) begin
                r ^= gmul4(col[31 - 8*j -: 8], coef[15 - 4*((j - i) & 3) -: 4]);
            end
            res[31 - 8*i -: 8] = r;
        end
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wr_en_q, wr_en_d;
    logic [1:0]  rd_idx_q, rd_idx_d;
    logic [1:0]  wr_idx_q, wr_idx_d;
    logic [31:0] col_q, col_d;
    logic [15:0] coef;
    logic [31:0] mix_src;

`ifdef MIX_INV_EN
    logic inv_q, inv_d;
    assign coef = inv_q ? 16'hebd9 : FWD;
`else
    logic unused_inverse;
    assign unused_inverse = inverse;
    assign coef = FWD;
`endif

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        wr_en_d  = wr_en_q;
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        col_d    = rd_data;
`ifdef MIX_INV_EN
        inv_d    = inv_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                wr_en_d = 1'b0;
                if (start) begin
                    state_d  = RUN;
                    step_d   = 3'd0;
                    busy_d   = 1'b1;
                    rd_idx_d = 2'd0;
                    wr_idx_d = 2'd0;
                    wr_en_d  = (PIPE == 0);
`ifdef MIX_INV_EN
                    inv_d    = inverse;
`endif
                end
            end
            RUN: begin
                if (step_q == LAST) begin
                    state_d = DONE;
                    wr_en_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // Reads stop at column 3; the pipelined variant spends one extra cycle writing it.
                    step_d   = step_q + 3'd1;
                    rd_idx_d = step_d[2] ? 2'd3 : step_d[1:0];
                    wr_idx_d = 2'(step_d - LAG);
                    wr_en_d  = 1'b1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                rd_idx_d = 2'd0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            step_q   <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_idx_q <= 2'd0;
            wr_idx_q <= 2'd0;
`ifdef MIX_INV_EN
            inv_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_en_q  <= wr_en_d;
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
`ifdef MIX_INV_EN
            inv_q    <= inv_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        col_q <= col_d;
    end

    assign mix_src    = (PIPE != 0) ? col_q : rd_data;
    assign wr_data    = wr_en_q ? mix_col(mix_src, coef) : 32'h0;
    assign busy       = busy_q;
    assign done       = done_q;
    assign wr_en      = wr_en_q;
    assign rd_idx     = rd_idx_q;
    assign wr_idx     = wr_idx_q;
    assign rd_row_col = 1'b1;
    assign wr_row_col = 1'b1;
endmodule
